// File: rtl/fft_transpose_4x4.sv
// Ping-pong 4x4 corner-turn: rows in, columns out, one beat per cycle; column 0 valid 1 cycle after the 4th row.
// i_in_valid is refused only while both banks are full; column outputs hold steady until i_out_ready accepts them.
module fft_transpose_4x4 #(
  parameter int DATA_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [4*DATA_W-1:0]   i_in_real,
  input  logic [4*DATA_W-1:0]   i_in_imag,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [4*DATA_W-1:0]   o_out_real,
  output logic [4*DATA_W-1:0]   o_out_imag,
  output logic [1:0]            o_out_col,
  output logic                  o_out_last
);

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  cplx_t       r_mem [2][4][4];
  logic [1:0]  r_full;
  logic        r_wr_bank;
  logic [1:0]  r_wr_row;
  logic        r_rd_bank;
  logic [1:0]  r_rd_col;

  logic        w_wr_fire;
  logic        w_rd_fire;
  logic [1:0]  w_full_nxt;

  assign o_in_ready  = !i_rst && !r_full[r_wr_bank];
  assign o_out_valid = r_full[r_rd_bank];
  assign w_wr_fire   = i_in_valid && o_in_ready;
  assign w_rd_fire   = o_out_valid && i_out_ready;

  // Write and read always target different banks, so set and clear never collide.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_fire && (r_wr_row == 2'd3)) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_fire && (r_rd_col == 2'd3)) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_wr_row  <= 2'd0;
      r_rd_bank <= 1'b0;
      r_rd_col  <= 2'd0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_fire) begin
        r_wr_row <= r_wr_row + 2'd1;
        if (r_wr_row == 2'd3) r_wr_bank <= ~r_wr_bank;
      end
      if (w_rd_fire) begin
        r_rd_col <= r_rd_col + 2'd1;
        if (r_rd_col == 2'd3) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Storage is never cleared; the full flags alone decide what is visible.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire) begin
      for (int k = 0; k < 4; k++) begin
        r_mem[r_wr_bank][r_wr_row][k].re <= i_in_real[k*DATA_W +: DATA_W];
        r_mem[r_wr_bank][r_wr_row][k].im <= i_in_imag[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    o_out_real = '0;
    o_out_imag = '0;
    o_out_col  = 2'd0;
    o_out_last = 1'b0;
    if (o_out_valid) begin
      for (int k = 0; k < 4; k++) begin
        o_out_real[k*DATA_W +: DATA_W] = r_mem[r_rd_bank][k][r_rd_col].re;
        o_out_imag[k*DATA_W +: DATA_W] = r_mem[r_rd_bank][k][r_rd_col].im;
      end
      o_out_col  = r_rd_col;
      o_out_last = (r_rd_col == 2'd3);
    end
  end

endmodule

// File: tb/tb_fft_transpose_4x4.sv
// Bench for fft_transpose_4x4: scoreboard of expected column beats built from the rows driven.
module tb_fft_transpose_4x4;
  localparam int DW = 16;
  localparam int LW = 4 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_last;
  logic [LW-1:0] in_real, in_imag, out_real, out_imag;
  logic [1:0]    out_col;

  int n_checks = 0;
  int n_fail   = 0;

  logic [LW-1:0] q_re[$];
  logic [LW-1:0] q_im[$];
  logic [1:0]    q_col[$];
  logic          q_last[$];
  logic [LW-1:0] rows_re[4];
  logic [LW-1:0] rows_im[4];
  int            wr_cnt = 0;

  always #5 clk = ~clk;

  fft_transpose_4x4 #(.DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_real(in_real), .i_in_imag(in_imag),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_real(out_real), .o_out_imag(out_imag),
    .o_out_col(out_col), .o_out_last(out_last)
  );

  // Reference transpose: once 4 rows are in, queue the 4 expected column beats.
  task automatic model_write(input logic [LW-1:0] re, input logic [LW-1:0] im);
    logic [LW-1:0] cre, cim;
    rows_re[wr_cnt] = re;
    rows_im[wr_cnt] = im;
    wr_cnt++;
    if (wr_cnt == 4) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 4; k++) begin
          cre[k*DW +: DW] = rows_re[k][c*DW +: DW];
          cim[k*DW +: DW] = rows_im[k][c*DW +: DW];
        end
        q_re.push_back(cre);
        q_im.push_back(cim);
        q_col.push_back(2'(c));
        q_last.push_back(c == 3);
      end
      wr_cnt = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [LW-1:0] re, input logic [LW-1:0] im, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_real   = re;
    in_imag   = im;
    out_ready = ordy;
    #1;
  endtask

  function automatic logic [LW-1:0] rand_row();
    logic [LW-1:0] v;
    for (int k = 0; k < 4; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_real = '0; in_imag = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_col !== 2'd0 ||
        out_real !== '0 || out_imag !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b out_last=%b out_col=%0d re=%h im=%h, required 0,0,0,0,0,0",
               in_ready, out_valid, out_last, out_col, out_real, out_imag);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1,0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_frame();
    logic [LW-1:0] re, im, ere, eim;
    logic [DW-1:0] v;
    for (int cyc = 0; cyc < 9; cyc++) begin
      re = '0; im = '0;
      if (cyc < 4) begin
        for (int k = 0; k < 4; k++) begin
          v = DW'(16 * cyc + k);
          re[k*DW +: DW] = v;
          im[k*DW +: DW] = -v;
        end
      end
      drive(cyc < 4, re, im, 1'b1);
      n_checks++;
      if (out_valid !== (cyc >= 4 && cyc < 8)) begin
        n_fail++;
        $display("FAIL single_valid cyc%0d: out_valid=%b required %b", cyc, out_valid, (cyc >= 4 && cyc < 8));
      end
      if (out_valid && out_ready) begin
        for (int k = 0; k < 4; k++) begin
          v = DW'(16 * k + (cyc - 4));
          ere[k*DW +: DW] = v;
          eim[k*DW +: DW] = -v;
        end
        n_checks++;
        if (out_real !== ere || out_imag !== eim || out_col !== 2'(cyc - 4) || out_last !== (cyc == 7)) begin
          n_fail++;
          $display("FAIL single_col%0d: re=%h im=%h col=%0d last=%b required re=%h im=%h col=%0d last=%b",
                   cyc - 4, out_real, out_imag, out_col, out_last, ere, eim, cyc - 4, cyc == 7);
        end
        void'(q_re.pop_front()); void'(q_im.pop_front()); void'(q_col.pop_front()); void'(q_last.pop_front());
      end
      if (in_valid && in_ready) model_write(in_real, in_imag);
    end
    n_checks++;
    if (q_re.size() != 0) begin
      n_fail++;
      $display("FAIL single_drain: %0d beats outstanding, required 0", q_re.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] re, im, ere, eim;
    int sent = 0, beats = 0, first = -1;
    for (int cyc = 0; cyc < 40 && !(sent == 12 && beats == 12); cyc++) begin
      for (int k = 0; k < 4; k++) re[k*DW +: DW] = DW'(256 * (sent / 4) + 16 * (sent % 4) + k);
      im = rand_row();
      drive(sent < 12, re, im, 1'b1);
      if (sent < 12) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready cyc%0d: in_ready=%b required 1", cyc, in_ready);
        end
      end
      if (first >= 0 && beats < 12) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_gap cyc%0d: out_valid=%b required 1", cyc, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        if (first < 0) first = cyc;
        beats++;
        n_checks++;
        if (q_re.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_beat: extra beat col=%0d, required none", out_col);
        end else begin
          ere = q_re.pop_front(); eim = q_im.pop_front();
          if (out_real !== ere || out_imag !== eim || out_col !== q_col[0] || out_last !== q_last[0]) begin
            n_fail++;
            $display("FAIL b2b_beat: re=%h im=%h col=%0d last=%b required re=%h im=%h col=%0d last=%b",
                     out_real, out_imag, out_col, out_last, ere, eim, q_col[0], q_last[0]);
          end
          void'(q_col.pop_front()); void'(q_last.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        model_write(in_real, in_imag);
        sent++;
      end
    end
    n_checks++;
    if (beats != 12 || first != 4) begin
      n_fail++;
      $display("FAIL b2b_count: beats=%0d first_cyc=%0d required 12 and 4", beats, first);
    end
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] re, im, ere, eim;
    int sent = 0;
    int cyc;
    re = rand_row(); im = rand_row();
    for (cyc = 0; cyc < 60 && !(sent == 12 && q_re.size() == 0); cyc++) begin
      drive(sent < 12, re, im, cyc >= 9);
      if (cyc < 8 || cyc == 13) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_ready_hi cyc%0d: in_ready=%b required 1", cyc, in_ready);
        end
      end else if (cyc <= 12) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_ready_lo cyc%0d: in_ready=%b required 0", cyc, in_ready);
        end
      end
      if (cyc >= 4 && cyc <= 8) begin
        n_checks++;
        if (q_re.size() == 0 || out_valid !== 1'b1 || out_col !== 2'd0 || out_real !== q_re[0] || out_imag !== q_im[0]) begin
          n_fail++;
          $display("FAIL bp_hold cyc%0d: out_valid=%b col=%0d re=%h, required frame 0 column 0 held",
                   cyc, out_valid, out_col, out_real);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q_re.size() == 0) begin
          n_fail++;
          $display("FAIL bp_beat: extra beat col=%0d, required none", out_col);
        end else begin
          ere = q_re.pop_front(); eim = q_im.pop_front();
          if (out_real !== ere || out_imag !== eim || out_col !== q_col[0] || out_last !== q_last[0]) begin
            n_fail++;
            $display("FAIL bp_beat: re=%h im=%h col=%0d last=%b required re=%h im=%h col=%0d last=%b",
                     out_real, out_imag, out_col, out_last, ere, eim, q_col[0], q_last[0]);
          end
          void'(q_col.pop_front()); void'(q_last.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        model_write(in_real, in_imag);
        sent++;
        re = rand_row(); im = rand_row();
      end
    end
    n_checks++;
    if (sent != 12 || q_re.size() != 0) begin
      n_fail++;
      $display("FAIL bp_done: rows=%0d outstanding=%0d required 12 and 0", sent, q_re.size());
    end
  endtask

  task automatic test_random_stalls();
    logic [LW-1:0] re, im, ere, eim, p_re, p_im;
    logic [1:0] p_col;
    logic p_last;
    logic hold = 1'b0;
    int sent = 0;
    re = rand_row(); im = rand_row();
    for (int cyc = 0; cyc < 5000 && !(sent == 200 && q_re.size() == 0); cyc++) begin
      drive(sent < 200 && $urandom_range(0, 9) < 7, re, im, $urandom_range(0, 9) < 7);
      if (hold) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_real !== p_re || out_imag !== p_im || out_col !== p_col || out_last !== p_last) begin
          n_fail++;
          $display("FAIL rand_stable cyc%0d: valid=%b re=%h col=%0d required valid=1 re=%h col=%0d",
                   cyc, out_valid, out_real, out_col, p_re, p_col);
        end
      end
      hold = out_valid && !out_ready;
      p_re = out_real; p_im = out_imag; p_col = out_col; p_last = out_last;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q_re.size() == 0) begin
          n_fail++;
          $display("FAIL rand_beat: extra beat col=%0d, required none", out_col);
        end else begin
          ere = q_re.pop_front(); eim = q_im.pop_front();
          if (out_real !== ere || out_imag !== eim || out_col !== q_col[0] || out_last !== q_last[0]) begin
            n_fail++;
            $display("FAIL rand_beat: re=%h im=%h col=%0d last=%b required re=%h im=%h col=%0d last=%b",
                     out_real, out_imag, out_col, out_last, ere, eim, q_col[0], q_last[0]);
          end
          void'(q_col.pop_front()); void'(q_last.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        model_write(in_real, in_imag);
        sent++;
        re = rand_row(); im = rand_row();
      end
    end
    n_checks++;
    if (sent != 200 || q_re.size() != 0) begin
      n_fail++;
      $display("FAIL rand_done: rows=%0d outstanding=%0d required 200 and 0", sent, q_re.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] ere, eim;
    int beats = 0;
    // Frame 0 in with output stalled, then 2 rows of frame 1 while columns 0 and 1 drain.
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive(1'b1, rand_row(), rand_row(), cyc >= 4);
      if (out_valid && out_ready) begin
        n_checks++;
        ere = q_re.pop_front(); eim = q_im.pop_front();
        if (out_real !== ere || out_imag !== eim || out_col !== q_col[0]) begin
          n_fail++;
          $display("FAIL rstmid_pre: re=%h col=%0d required re=%h col=%0d", out_real, out_col, ere, q_col[0]);
        end
        void'(q_col.pop_front()); void'(q_last.pop_front());
      end
      if (in_valid && in_ready) model_write(in_real, in_imag);
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_col !== 2'd2 || wr_cnt != 2) begin
      n_fail++;
      $display("FAIL rstmid_state: out_valid=%b out_col=%0d rows=%0d required 1, 2, 2", out_valid, out_col, wr_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    q_re.delete(); q_im.delete(); q_col.delete(); q_last.delete();
    wr_cnt = 0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_col !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_after: out_valid=%b in_ready=%b out_col=%0d required 0, 1, 0", out_valid, in_ready, out_col);
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive(cyc < 4, rand_row(), rand_row(), 1'b1);
      if (out_valid && out_ready) begin
        beats++;
        n_checks++;
        if (q_re.size() == 0) begin
          n_fail++;
          $display("FAIL rstmid_beat: residue beat col=%0d, required none", out_col);
        end else begin
          ere = q_re.pop_front(); eim = q_im.pop_front();
          if (out_real !== ere || out_imag !== eim || out_col !== q_col[0] || out_last !== q_last[0]) begin
            n_fail++;
            $display("FAIL rstmid_beat: re=%h im=%h col=%0d last=%b required re=%h im=%h col=%0d last=%b",
                     out_real, out_imag, out_col, out_last, ere, eim, q_col[0], q_last[0]);
          end
          void'(q_col.pop_front()); void'(q_last.pop_front());
        end
      end
      if (in_valid && in_ready) model_write(in_real, in_imag);
    end
    n_checks++;
    if (beats != 4 || q_re.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_count: beats=%0d outstanding=%0d required 4 and 0", beats, q_re.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_random_stalls();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_transpose_4x4.md
# fft_transpose_4x4

Double-buffered corner-turn memory for the 4x4 2D FFT datapath. It accepts the output of the row-pass 4-point FFT one row (4 complex samples) per beat. Once a full 4x4 frame is stored, it emits the frame one column per beat to the column-pass 4-point FFT. Two ping-pong banks let one frame fill while the previous frame drains, so back-to-back frames sustain one beat per cycle.

## Interface
- `DATA_W`, default 16: width of each real or imaginary component, two's complement.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  row beat present on `in_real`/`in_imag`.
- `in_ready`  out  1  block can accept a row beat this cycle.
- `in_real`  in  4*DATA_W  row lanes; lane k (column index k) at bits [k*DATA_W +: DATA_W].
- `in_imag`  in  4*DATA_W  imaginary parts, same lane packing.
- `out_valid`  out  1  column beat present on `out_real`/`out_imag`.
- `out_ready`  in  1  downstream accepts the column beat this cycle.
- `out_real`  out  4*DATA_W  column lanes; lane k = element of row k.
- `out_imag`  out  4*DATA_W  imaginary parts, same packing.
- `out_col`  out  2  index (0..3) of the column currently presented.
- `out_last`  out  1  high with column 3 of a frame.

## Operation
- Storage: 2 banks x 4 rows x 4 lanes x (real, imag), registers. No arithmetic; data passes through bit-exact.
- State:
  - `wr_bank` (1b), `wr_row` (2b).
  - `rd_bank` (1b), `rd_col` (2b).
  - `full[1:0]`, one flag per bank.
- Write side:
  - `in_ready = !rst && !full[wr_bank]`.
  - On `in_valid && in_ready`, store lane k into bank[wr_bank].row[wr_row].lane[k], then increment `wr_row`.
  - When `wr_row` wraps 3->0, set `full[wr_bank]` and toggle `wr_bank`.
- Read side:
  - `out_valid = full[rd_bank]`.
  - Output lane k = bank[rd_bank].row[k].lane[rd_col]; `out_col = rd_col`; `out_last = out_valid && rd_col==3`.
  - On `out_valid && out_ready`, increment `rd_col`. When it wraps 3->0, clear `full[rd_bank]` and toggle `rd_bank`.
  - While `out_valid` is 0, `out_real`, `out_imag`, `out_col` and `out_last` drive all-zero.
- Bank states, derived: EMPTY (`!full`, not write target) -> FILLING (write target, `wr_row`>0) -> FULL (`full` set) -> DRAINING (read target, `rd_col`>0) -> EMPTY.
- Simultaneous events:
  - Setting `full` on one bank and clearing it on the other in the same cycle are independent; both take effect.
  - A bank freed by the last read becomes writable the next cycle. There is no combinational path from `out_ready` to `in_ready`.
  - `in_valid` while `in_ready`=0: input ignored, no state change. The upstream stage holds its data.
- Both banks full: `in_ready`=0 until column 3 of `rd_bank` is accepted.
- Reset (any time, including mid-frame or mid-drain):
  - `full`=0, `wr_bank`=`rd_bank`=0, `wr_row`=`rd_col`=0.
  - Partial frames are discarded; storage contents are not cleared.
  - In the cycle after reset deasserts: `in_ready`=1 and `out_valid`=0.

## Timing
- Reset values: `in_ready` 0 during reset and 1 after; `out_valid` 0, `out_last` 0, `out_col` 0, `out_real`/`out_imag` 0.
- Latency: the 4th row is accepted at edge N, and column 0 is valid in the cycle after edge N (1 cycle).
- Throughput: 1 beat/cycle sustained with `out_ready` held high. Frame F+1 fills while frame F drains.
- Output stability: while `out_valid && !out_ready`, all output fields hold constant.
- `out_valid` never deasserts without a handshake.
- Outputs are a combinational mux of registered state; no input-to-output combinational path.

## Test plan
- **Single frame.** Write 4 rows with row r lane k real=16r+k and imag=-(16r+k); hold `out_ready`=1.
  - Required: columns c=0..3 on consecutive cycles, lane k real=16k+c and imag=-(16k+c).
  - `out_last` high only with c=3; `out_valid` first high 1 cycle after the 4th write.
- **Back-to-back frames.** 3 frames, `in_valid`=1 and `out_ready`=1 continuously.
  - Required: `in_ready` never drops; 12 column beats with no gaps after the first; frame order preserved, bank toggling correct.
- **Backpressure.** `out_ready`=0 while writing 8 rows, then a 9th row is offered.
  - Required: `in_ready`=0 after 8 rows; the 9th row is not accepted.
  - Outputs hold frame 0 column 0.
  - After 4 reads, `in_ready` returns to 1 one cycle after column 3 is accepted.
- **Random stalls.** Random `in_valid`/`out_ready` over 50 frames.
  - Required: output stream equals the golden transpose.
  - No beat lost or duplicated; outputs stable across every stall.
- **Reset mid-operation.** Assert `rst` after 2 rows of frame 1 while frame 0 is at column 2.
  - Required: the next cycle shows `out_valid`=0, `in_ready`=1, `out_col`=0.
  - A new 4-row frame then reads out correctly with no residue from the old one.
